esc_seq_tracker: RTL

- Upstream stage of the escape-sequence classifier (to_save).
- Consumes a raw 8-bit terminal byte stream and tracks ANSI/VT escape-sequence progress: ESC (0x1B), CSI '[' (0x5B), parameter bytes, final byte.
- Re-emits each byte one cycle later together with thermometer stage flags ESC1/ESC2/ESC3 that drive the downstream classifier directly.
- Also provides sequence-end and abort pulses, including an inactivity timeout.

---
 rtl/esc_seq_tracker_if.sv | 25 ++
 rtl/esc_seq_tracker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/esc_seq_tracker_if.sv
// Byte-stream interface for the escape-sequence tracker: raw bytes in,
// delayed bytes plus thermometer stage flags and sequence pulses out.
interface esc_seq_tracker_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       out_valid;
  logic [7:0] byte_out;
  logic       ESC1;
  logic       ESC2;
  logic       ESC3;
  logic       seq_end;
  logic       seq_abort;

  // Producer side: drives raw bytes, observes the tracker outputs.
  modport master (
    output in_valid, in_byte,
    input  out_valid, byte_out, ESC1, ESC2, ESC3, seq_end, seq_abort
  );

  // Tracker side.
  modport slave (
    input  in_valid, in_byte,
    output out_valid, byte_out, ESC1, ESC2, ESC3, seq_end, seq_abort
  );
endinterface

// File: rtl/esc_seq_tracker.sv
// Escape-sequence tracker: follows ESC / CSI / parameter / final progress of
// an 8-bit terminal stream and re-emits each byte one cycle later with
// thermometer stage flags and end/abort pulses, including an inactivity
// timeout while a sequence is open.
module esc_seq_tracker #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_PARAM_LEN  = 8,
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  esc_seq_tracker_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ESC   = 2'd1,
    ST_CSI   = 2'd2,
    ST_PARAM = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PARAM_MAX = CNT_W'(MAX_PARAM_LEN);

  function automatic logic is_final(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

  function automatic logic is_param(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) || (b == 8'h3B);
  endfunction

  function automatic logic is_print(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] param_len_q, param_len_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       byte_q, byte_d;
  logic             esc1_q, esc1_d;
  logic             esc2_q, esc2_d;
  logic             esc3_q, esc3_d;
  logic             seq_end_q, seq_end_d;
  logic             seq_abort_q, seq_abort_d;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    param_len_d = param_len_q;
    idle_cnt_d  = idle_cnt_q;
    out_valid_d = bus.in_valid;
    byte_d      = byte_q;
    esc1_d      = esc1_q;
    esc2_d      = esc2_q;
    esc3_d      = esc3_q;
    seq_end_d   = 1'b0;
    seq_abort_d = 1'b0;

    if (bus.in_valid) begin
      idle_cnt_d = {CNT_W{1'b0}};
      byte_d     = bus.in_byte;
      // Flags report the stage the byte arrived in, before it is consumed.
      esc1_d     = (state_q != ST_IDLE);
      esc2_d     = (state_q == ST_CSI) || (state_q == ST_PARAM);
      esc3_d     = (state_q == ST_PARAM);
      case (state_q)
        ST_IDLE: begin
          if (bus.in_byte == 8'h1B) begin
            state_d = ST_ESC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ESC: begin
          if (bus.in_byte == 8'h5B) begin
            state_d = ST_CSI;
          end else if (bus.in_byte == 8'h1B) begin
            state_d = ST_ESC;
          end else if (is_print(bus.in_byte)) begin
            state_d   = ST_IDLE;
            seq_end_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            seq_abort_d = 1'b1;
          end
        end
        ST_CSI, ST_PARAM: begin
          if (is_param(bus.in_byte)) begin
            if ((state_q == ST_CSI) || (param_len_q < PARAM_MAX)) begin
              state_d     = ST_PARAM;
              param_len_d = param_len_q + CNT_W'(1);
            end else begin
              state_d     = ST_IDLE;
              seq_abort_d = 1'b1;
            end
          end else if (is_final(bus.in_byte)) begin
            state_d   = ST_IDLE;
            seq_end_d = 1'b1;
          end else if (bus.in_byte == 8'h1B) begin
            state_d     = ST_ESC;
            seq_abort_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            seq_abort_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // Silence inside an open sequence: abort once the budget is used up.
      if (idle_cnt_q == TO_LAST) begin
        state_d     = ST_IDLE;
        seq_abort_d = 1'b1;
        idle_cnt_d  = {CNT_W{1'b0}};
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end else begin
      idle_cnt_d = {CNT_W{1'b0}};
    end

    // The parameter count only has meaning while in the parameter phase.
    if (state_d != ST_PARAM) begin
      param_len_d = {CNT_W{1'b0}};
    end else begin
      param_len_d = param_len_d;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      param_len_q <= {CNT_W{1'b0}};
      idle_cnt_q  <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      byte_q      <= 8'h00;
      esc1_q      <= 1'b0;
      esc2_q      <= 1'b0;
      esc3_q      <= 1'b0;
      seq_end_q   <= 1'b0;
      seq_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      param_len_q <= param_len_d;
      idle_cnt_q  <= idle_cnt_d;
      out_valid_q <= out_valid_d;
      byte_q      <= byte_d;
      esc1_q      <= esc1_d;
      esc2_q      <= esc2_d;
      esc3_q      <= esc3_d;
      seq_end_q   <= seq_end_d;
      seq_abort_q <= seq_abort_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.byte_out  = byte_q;
  assign bus.ESC1      = esc1_q;
  assign bus.ESC2      = esc2_q;
  assign bus.ESC3      = esc3_q;
  assign bus.seq_end   = seq_end_q;
  assign bus.seq_abort = seq_abort_q;

endmodule
